vram_slot_arbiter: RTL and testbench
====================================

Name: vram_slot_arbiter

Overview:
- Shares one single-port video RAM between the video tile/sprite fetcher and the CPU.
- Access slots are timed by the pixel-clock enable; blanking state comes from the raster timing generator.
- Video has priority during active display, CPU during blanking.
- Sits between the timing generator, the fetch pipeline, the CPU bus and the VRAM.

Parameters:
- AW, 16, VRAM address width.
- DW, 8, VRAM data width.
- RAM_LAT, 2, MCLK cycles from RAM_CE to RAM_DIN valid (1..3; must be < MCLK cycles per PCLK_EN).
- STARVE_MAX, 8, slots the CPU may be denied before forced grant (optional feature only).

Ports:
- MCLK  in  1  master clock
- RST_N  in  1  asynchronous active-low reset
- PCLK_EN  in  1  one-MCLK pixel enable; marks slot boundary
- HBLK  in  1  horizontal blank from timing generator
- VBLK  in  1  vertical blank from timing generator
- VID_REQ  in  1  video fetch request, level, held until VID_ACK
- VID_ADDR  in  AW  video fetch address
- VID_DATA  out  DW  video read data, valid with VID_ACK
- VID_ACK  out  1  one-MCLK completion pulse
- CPU_REQ  in  1  CPU request, level, held until CPU_ACK
- CPU_WE  in  1  1 = write
- CPU_ADDR  in  AW  CPU address
- CPU_DIN  in  DW  CPU write data
- CPU_DOUT  out  DW  CPU read data, valid with CPU_ACK
- CPU_ACK  out  1  one-MCLK completion pulse
- RAM_ADDR  out  AW  VRAM address
- RAM_DOUT  out  DW  VRAM write data
- RAM_DIN  in  DW  VRAM read data
- RAM_CE  out  1  VRAM chip enable, one-MCLK strobe
- RAM_WE  out  1  VRAM write enable, qualified by RAM_CE

Behaviour:
- Reset (async, RST_N=0): state IDLE.
  - All outputs 0: ACKs, RAM_CE, RAM_WE, RAM_ADDR, RAM_DOUT, VID_DATA, CPU_DOUT.
  - Starve counter 0.
  - In-flight access is dropped; no ACK is issued after release.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: arbitration occurs only on an MCLK edge with PCLK_EN=1.
  - Active display (HBLK|VBLK=0): VID_REQ wins over CPU_REQ.
  - Blanking: CPU_REQ wins over VID_REQ.
  - A lone request is granted regardless of blanking state.
  - No request: stay IDLE.
- Grant, same cycle:
  - Latch owner, address, WE, write data.
  - RAM_CE=1 for exactly one MCLK.
  - RAM_WE=CPU_WE for a CPU grant; always 0 for a video grant.
  - Go to ACCESS.
- ACCESS: count RAM_LAT MCLK cycles from the CE cycle.
  - On the final count, capture RAM_DIN into VID_DATA or CPU_DOUT (read only; CPU_DOUT unchanged on a write).
  - Go to DONE.
- DONE: pulse the owner's ACK for one MCLK, then go to IDLE.
  - Total latency from grant edge to ACK = RAM_LAT+1 MCLK.
- PCLK_EN during ACCESS/DONE is ignored. That slot is lost, not queued.
- RAM_ADDR and RAM_DOUT hold their last values between accesses.
- Requester drops REQ before ACK: the access completes and ACK still pulses.
- REQ still high in the cycle after ACK: treated as a new request at the next slot.
- Never both ACKs in the same cycle. Never RAM_CE while in ACCESS/DONE.
- HBLK/VBLK are sampled only at the arbitration edge. A blank change mid-access has no effect.

Optional Feature:
- Macro: VRAM_CPU_STARVE_GUARD_EN.
- Defined:
  - 4-bit starve counter increments on each arbitration edge where CPU_REQ=1 but video is granted.
  - Counter clears on CPU grant or when CPU_REQ=0.
  - When counter ≥ STARVE_MAX, the CPU wins the next slot even in active display; the counter then clears.
- Undefined: no counter. CPU is strictly blocked while VID_REQ is asserted in active display.

Decomposition:
- Shared package vram_pkg:
  - owner enum {OWN_NONE, OWN_VID, OWN_CPU}
  - FSM state enum {S_IDLE, S_ACCESS, S_DONE}
  - AW/DW defaults
- One natural sub-module: vram_slot_prio, the combinational priority/starve decision (inputs: reqs, blank, starve count; output: owner).
- Everything else stays in the top module.

Test Plan:
- Active display, RAM_LAT=2, both REQs at a PCLK_EN edge:
  - VID grant, RAM_CE one cycle, RAM_WE=0.
  - VID_ACK 3 MCLK later with VID_DATA=RAM_DIN; CPU_ACK at the next slot.
- HBLK=1, both REQs, CPU write addr 0x1234 data 0xA5:
  - CPU granted, RAM_WE=1, RAM_ADDR=0x1234, RAM_DOUT=0xA5.
  - CPU_ACK after 3 MCLK; video served at the following slot.
- PCLK_EN every 2 MCLK with RAM_LAT=2:
  - Alternate PCLK_EN edges are ignored during ACCESS/DONE.
  - Exactly one RAM_CE per two slots.
- RST_N low during ACCESS:
  - All outputs 0 immediately.
  - No ACK after release; next grant is at the first PCLK_EN after release.
- Guard defined, STARVE_MAX=8, VID_REQ and CPU_REQ held in active display:
  - 8 video grants, then the 9th slot grants the CPU, then video resumes.
  - With the macro undefined, the CPU is never granted.
- CPU_REQ dropped one cycle after grant:
  - CPU_ACK still pulses once; no second access is issued.

Source files
------------

// File: rtl/vram_slot_arbiter_pkg.sv
// Shared types for the VRAM slot arbiter: bus widths, access owner and FSM state encodings.
package vram_pkg;

    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ACCESS = 2'd1;
    localparam state_t S_DONE   = 2'd2;

endpackage

// File: rtl/vram_slot_arbiter_if.sv
// Video fetch, CPU and VRAM bus bundle; the arbiter is the slave, requesters and RAM form the master side.
interface vram_slot_arbiter_if
    import vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
);

    logic          VID_REQ;
    logic [AW-1:0] VID_ADDR;
    logic [DW-1:0] VID_DATA;
    logic          VID_ACK;

    logic          CPU_REQ;
    logic          CPU_WE;
    logic [AW-1:0] CPU_ADDR;
    logic [DW-1:0] CPU_DIN;
    logic [DW-1:0] CPU_DOUT;
    logic          CPU_ACK;

    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DOUT;
    logic [DW-1:0] RAM_DIN;
    logic          RAM_CE;
    logic          RAM_WE;

    modport slave (
        input  VID_REQ, VID_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, RAM_DIN,
        output VID_DATA, VID_ACK, CPU_DOUT, CPU_ACK, RAM_ADDR, RAM_DOUT, RAM_CE, RAM_WE
    );

    modport master (
        output VID_REQ, VID_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, RAM_DIN,
        input  VID_DATA, VID_ACK, CPU_DOUT, CPU_ACK, RAM_ADDR, RAM_DOUT, RAM_CE, RAM_WE
    );

endinterface

// File: rtl/vram_slot_arbiter_prio.sv
// Combinational slot owner decision: video first in active display, CPU first in blanking or when starved.
module vram_slot_prio
    import vram_pkg::*;
#(
    parameter int STARVE_MAX = 8
)
(
    input  logic       vid_req,
    input  logic       cpu_req,
    input  logic       blank,
    input  logic [3:0] starve_cnt,
    output owner_t     owner
);

    logic starve_hit;

    // Without the starve guard the count is tied to zero, so this never fires.
    assign starve_hit = int'(starve_cnt) >= STARVE_MAX;

    always_comb begin
        owner = OWN_NONE;
        if (vid_req && cpu_req) begin
            owner = (blank || starve_hit) ? OWN_CPU : OWN_VID;
        end else if (vid_req) begin
            owner = OWN_VID;
        end else if (cpu_req) begin
            owner = OWN_CPU;
        end
    end

endmodule

// File: rtl/vram_slot_arbiter.sv
// Single-port VRAM slot arbiter between video fetch and CPU, one access per pixel-enable slot.
// Define VRAM_CPU_STARVE_GUARD_EN to force a CPU grant after STARVE_MAX denied slots.
//
// state    | meaning
// S_IDLE   | waiting for a PCLK_EN slot with a pending request
// S_ACCESS | RAM_CE issued, counting RAM_LAT cycles to read data
// S_DONE   | owner's ACK high for this cycle, back to idle next
module vram_slot_arbiter
    import vram_pkg::*;
#(
    parameter int AW         = VRAM_AW,
    parameter int DW         = VRAM_DW,
    parameter int RAM_LAT    = 2,
    parameter int STARVE_MAX = 8
)
(
    input  logic MCLK,
    input  logic RST_N,
    input  logic PCLK_EN,
    input  logic HBLK,
    input  logic VBLK,
    vram_slot_arbiter_if.slave bus
);

    state_t     state;
    owner_t     owner;
    owner_t     grant;
    logic [1:0] lat_cnt;
    logic       we_q;
    logic [3:0] starve_cnt;
    logic       arb;

    assign arb = (state == S_IDLE) && PCLK_EN;

    vram_slot_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .vid_req    (bus.VID_REQ),
        .cpu_req    (bus.CPU_REQ),
        .blank      (HBLK | VBLK),
        .starve_cnt (starve_cnt),
        .owner      (grant)
    );

`ifdef VRAM_CPU_STARVE_GUARD_EN
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_cnt <= '0;
        end else if (!bus.CPU_REQ) begin
            starve_cnt <= '0;
        end else if (arb) begin
            if (grant == OWN_CPU) begin
                starve_cnt <= '0;
            end else if (grant == OWN_VID && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    assign starve_cnt = '0;
`endif

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            owner        <= OWN_NONE;
            lat_cnt      <= '0;
            we_q         <= 1'b0;
            bus.RAM_CE   <= 1'b0;
            bus.RAM_WE   <= 1'b0;
            bus.RAM_ADDR <= '0;
            bus.RAM_DOUT <= '0;
            bus.VID_DATA <= '0;
            bus.CPU_DOUT <= '0;
            bus.VID_ACK  <= 1'b0;
            bus.CPU_ACK  <= 1'b0;
        end else begin
            bus.RAM_CE  <= 1'b0;
            bus.RAM_WE  <= 1'b0;
            bus.VID_ACK <= 1'b0;
            bus.CPU_ACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb && grant != OWN_NONE) begin
                        owner      <= grant;
                        state      <= S_ACCESS;
                        lat_cnt    <= 2'(RAM_LAT - 1);
                        bus.RAM_CE <= 1'b1;
                        if (grant == OWN_CPU) begin
                            bus.RAM_ADDR <= bus.CPU_ADDR;
                            bus.RAM_DOUT <= bus.CPU_DIN;
                            bus.RAM_WE   <= bus.CPU_WE;
                            we_q         <= bus.CPU_WE;
                        end else begin
                            bus.RAM_ADDR <= bus.VID_ADDR;
                            we_q         <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (lat_cnt == 2'd0) begin
                        if (!we_q && owner == OWN_VID) begin
                            bus.VID_DATA <= bus.RAM_DIN;
                        end
                        if (!we_q && owner == OWN_CPU) begin
                            bus.CPU_DOUT <= bus.RAM_DIN;
                        end
                        bus.VID_ACK <= (owner == OWN_VID);
                        bus.CPU_ACK <= (owner == OWN_CPU);
                        state       <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    owner <= OWN_NONE;
                    state <= S_IDLE;
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter (RAM_LAT=2, STARVE_MAX=8); honours VRAM_CPU_STARVE_GUARD_EN.
module tb_vram_slot_arbiter;

    logic MCLK;
    logic RST_N;
    logic PCLK_EN;
    logic HBLK;
    logic VBLK;

    int checks;
    int errors;

    vram_slot_arbiter_if #(.AW(16), .DW(8)) bus ();

    vram_slot_arbiter #(
        .AW         (16),
        .DW         (8),
        .RAM_LAT    (2),
        .STARVE_MAX (8)
    ) dut (
        .MCLK    (MCLK),
        .RST_N   (RST_N),
        .PCLK_EN (PCLK_EN),
        .HBLK    (HBLK),
        .VBLK    (VBLK),
        .bus     (bus)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    task automatic slot();
        PCLK_EN = 1'b1;
        cyc();
        PCLK_EN = 1'b0;
    endtask

    task automatic test_reset();
        RST_N        = 1'b0;
        PCLK_EN      = 1'b0;
        HBLK         = 1'b0;
        VBLK         = 1'b0;
        bus.VID_REQ  = 1'b0;
        bus.VID_ADDR = '0;
        bus.CPU_REQ  = 1'b0;
        bus.CPU_WE   = 1'b0;
        bus.CPU_ADDR = '0;
        bus.CPU_DIN  = '0;
        bus.RAM_DIN  = '0;
        cyc();
        cyc();
        checks++;
        if ({bus.RAM_CE, bus.RAM_WE, bus.VID_ACK, bus.CPU_ACK} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {bus.RAM_CE, bus.RAM_WE, bus.VID_ACK, bus.CPU_ACK});
        end
        checks++;
        if ({bus.RAM_ADDR, bus.RAM_DOUT, bus.VID_DATA, bus.CPU_DOUT} !== 40'h0) begin
            errors++;
            $display("FAIL reset_buses: got %h want 0",
                     {bus.RAM_ADDR, bus.RAM_DOUT, bus.VID_DATA, bus.CPU_DOUT});
        end
        RST_N = 1'b1;
        cyc();
    endtask

    task automatic test_vid_priority();
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h0040;
        bus.CPU_REQ  = 1'b1;
        bus.CPU_WE   = 1'b0;
        bus.CPU_ADDR = 16'h0100;
        bus.RAM_DIN  = 8'h3C;
        slot();
        checks++;
        if ({bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR} !== {2'b10, 16'h0040}) begin
            errors++;
            $display("FAIL vid_grant: ce/we/addr got %b/%b/%h want 1/0/0040",
                     bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR);
        end
        cyc();
        checks++;
        if (bus.RAM_CE !== 1'b0) begin
            errors++;
            $display("FAIL vid_ce_width: got %b want 0", bus.RAM_CE);
        end
        cyc();
        checks++;
        if ({bus.VID_ACK, bus.CPU_ACK, bus.VID_DATA} !== {2'b10, 8'h3C}) begin
            errors++;
            $display("FAIL vid_ack: vack/cack/data got %b/%b/%h want 1/0/3c",
                     bus.VID_ACK, bus.CPU_ACK, bus.VID_DATA);
        end
        bus.VID_REQ = 1'b0;
        cyc();
        checks++;
        if (bus.VID_ACK !== 1'b0) begin
            errors++;
            $display("FAIL vid_ack_pulse: got %b want 0", bus.VID_ACK);
        end
        bus.RAM_DIN = 8'h5A;
        slot();
        checks++;
        if ({bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR} !== {2'b10, 16'h0100}) begin
            errors++;
            $display("FAIL cpu_next_slot: ce/we/addr got %b/%b/%h want 1/0/0100",
                     bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR);
        end
        cyc();
        cyc();
        checks++;
        if ({bus.CPU_ACK, bus.VID_ACK, bus.CPU_DOUT, bus.VID_DATA} !== {2'b10, 8'h5A, 8'h3C}) begin
            errors++;
            $display("FAIL cpu_read_ack: cack/vack/dout/vdata got %b/%b/%h/%h want 1/0/5a/3c",
                     bus.CPU_ACK, bus.VID_ACK, bus.CPU_DOUT, bus.VID_DATA);
        end
        bus.CPU_REQ = 1'b0;
        cyc();
    endtask

    task automatic test_blank_cpu_write();
        HBLK         = 1'b1;
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h0041;
        bus.CPU_REQ  = 1'b1;
        bus.CPU_WE   = 1'b1;
        bus.CPU_ADDR = 16'h1234;
        bus.CPU_DIN  = 8'hA5;
        bus.RAM_DIN  = 8'hFF;
        slot();
        checks++;
        if ({bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DOUT} !== {2'b11, 16'h1234, 8'hA5}) begin
            errors++;
            $display("FAIL blank_cpu_write: ce/we/addr/dout got %b/%b/%h/%h want 1/1/1234/a5",
                     bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DOUT);
        end
        cyc();
        cyc();
        checks++;
        if ({bus.CPU_ACK, bus.VID_ACK, bus.CPU_DOUT} !== {2'b10, 8'h5A}) begin
            errors++;
            $display("FAIL write_ack: cack/vack/dout got %b/%b/%h want 1/0/5a",
                     bus.CPU_ACK, bus.VID_ACK, bus.CPU_DOUT);
        end
        bus.CPU_REQ = 1'b0;
        bus.CPU_WE  = 1'b0;
        cyc();
        bus.RAM_DIN = 8'h77;
        slot();
        checks++;
        if ({bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DOUT} !== {2'b10, 16'h0041, 8'hA5}) begin
            errors++;
            $display("FAIL vid_after_write: ce/we/addr/dout got %b/%b/%h/%h want 1/0/0041/a5",
                     bus.RAM_CE, bus.RAM_WE, bus.RAM_ADDR, bus.RAM_DOUT);
        end
        cyc();
        cyc();
        checks++;
        if ({bus.VID_ACK, bus.VID_DATA} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL vid_after_write_ack: ack/data got %b/%h want 1/77",
                     bus.VID_ACK, bus.VID_DATA);
        end
        bus.VID_REQ = 1'b0;
        HBLK        = 1'b0;
        cyc();
    endtask

    task automatic test_slot_rate();
        logic [7:0] ce_seen;
        logic [7:0] ack_seen;
        ce_seen      = '0;
        ack_seen     = '0;
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h0200;
        for (int i = 0; i < 8; i++) begin
            PCLK_EN = (i % 2 == 0);
            cyc();
            ce_seen[i]  = bus.RAM_CE;
            ack_seen[i] = bus.VID_ACK;
        end
        PCLK_EN     = 1'b0;
        bus.VID_REQ = 1'b0;
        checks++;
        if (ce_seen !== 8'b0001_0001) begin
            errors++;
            $display("FAIL slot_rate_ce: got %b want 00010001", ce_seen);
        end
        checks++;
        if (ack_seen !== 8'b0100_0100) begin
            errors++;
            $display("FAIL slot_rate_ack: got %b want 01000100", ack_seen);
        end
        cyc();
    endtask

    task automatic test_cpu_drop();
        int acks;
        int ces;
        acks         = 0;
        ces          = 0;
        bus.CPU_REQ  = 1'b1;
        bus.CPU_WE   = 1'b0;
        bus.CPU_ADDR = 16'h0300;
        bus.RAM_DIN  = 8'h99;
        slot();
        checks++;
        if ({bus.RAM_CE, bus.RAM_ADDR} !== {1'b1, 16'h0300}) begin
            errors++;
            $display("FAIL drop_grant: ce/addr got %b/%h want 1/0300", bus.RAM_CE, bus.RAM_ADDR);
        end
        bus.CPU_REQ = 1'b0;
        for (int i = 0; i < 8; i++) begin
            PCLK_EN = (i % 2 == 1);
            cyc();
            if (bus.CPU_ACK === 1'b1) acks++;
            if (bus.RAM_CE === 1'b1) ces++;
        end
        PCLK_EN = 1'b0;
        checks++;
        if (acks != 1 || ces != 0) begin
            errors++;
            $display("FAIL drop_ack_once: acks/ces got %0d/%0d want 1/0", acks, ces);
        end
        checks++;
        if (bus.CPU_DOUT !== 8'h99) begin
            errors++;
            $display("FAIL drop_data: got %h want 99", bus.CPU_DOUT);
        end
    endtask

    task automatic test_starve();
        logic [9:0] cpu_grants;
        logic [9:0] exp_grants;
        int         ces;
        int         both_ack;
        cpu_grants = '0;
        ces        = 0;
        both_ack   = 0;
`ifdef VRAM_CPU_STARVE_GUARD_EN
        exp_grants = 10'b01_0000_0000;
`else
        exp_grants = 10'b00_0000_0000;
`endif
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h0A0A;
        bus.CPU_REQ  = 1'b1;
        bus.CPU_WE   = 1'b0;
        bus.CPU_ADDR = 16'h0C0C;
        for (int k = 0; k < 10; k++) begin
            slot();
            if (bus.RAM_CE === 1'b1) ces++;
            cpu_grants[k] = (bus.RAM_CE === 1'b1) && (bus.RAM_ADDR === 16'h0C0C);
            for (int j = 0; j < 3; j++) begin
                cyc();
                if (bus.VID_ACK === 1'b1 && bus.CPU_ACK === 1'b1) both_ack++;
            end
        end
        bus.VID_REQ = 1'b0;
        bus.CPU_REQ = 1'b0;
        checks++;
        if (cpu_grants !== exp_grants) begin
            errors++;
            $display("FAIL starve_pattern: cpu grants got %b want %b", cpu_grants, exp_grants);
        end
        checks++;
        if (ces != 10 || both_ack != 0) begin
            errors++;
            $display("FAIL starve_slots: ces/both_ack got %0d/%0d want 10/0", ces, both_ack);
        end
        cyc();
    endtask

    task automatic test_reset_mid_access();
        int acks;
        int ces;
        acks         = 0;
        ces          = 0;
        bus.CPU_REQ  = 1'b1;
        bus.CPU_WE   = 1'b0;
        bus.CPU_ADDR = 16'h2222;
        bus.RAM_DIN  = 8'hEE;
        slot();
        checks++;
        if ({bus.RAM_CE, bus.RAM_ADDR} !== {1'b1, 16'h2222}) begin
            errors++;
            $display("FAIL rst_pre_grant: ce/addr got %b/%h want 1/2222", bus.RAM_CE, bus.RAM_ADDR);
        end
        cyc();
        RST_N = 1'b0;
        #1;
        checks++;
        if ({bus.RAM_CE, bus.RAM_WE, bus.VID_ACK, bus.CPU_ACK, bus.RAM_ADDR,
             bus.RAM_DOUT, bus.VID_DATA, bus.CPU_DOUT} !== 44'h0) begin
            errors++;
            $display("FAIL rst_mid_access: outputs got %h want 0",
                     {bus.RAM_CE, bus.RAM_WE, bus.VID_ACK, bus.CPU_ACK, bus.RAM_ADDR,
                      bus.RAM_DOUT, bus.VID_DATA, bus.CPU_DOUT});
        end
        cyc();
        cyc();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.CPU_ACK === 1'b1) acks++;
            if (bus.RAM_CE === 1'b1) ces++;
        end
        checks++;
        if (acks != 0 || ces != 0) begin
            errors++;
            $display("FAIL rst_no_ack: acks/ces got %0d/%0d want 0/0", acks, ces);
        end
        slot();
        checks++;
        if ({bus.RAM_CE, bus.RAM_ADDR} !== {1'b1, 16'h2222}) begin
            errors++;
            $display("FAIL rst_regrant: ce/addr got %b/%h want 1/2222", bus.RAM_CE, bus.RAM_ADDR);
        end
        cyc();
        cyc();
        checks++;
        if ({bus.CPU_ACK, bus.CPU_DOUT} !== {1'b1, 8'hEE}) begin
            errors++;
            $display("FAIL rst_regrant_ack: ack/dout got %b/%h want 1/ee", bus.CPU_ACK, bus.CPU_DOUT);
        end
        bus.CPU_REQ = 1'b0;
        cyc();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vid_priority();
        test_blank_cpu_write();
        test_slot_rate();
        test_cpu_drop();
        test_starve();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
